// File: rtl/dma_sched_pkg.sv
// rtl/dma_sched_pkg.sv - shared state encoding and DMA register map for the transfer scheduler
package dma_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_START,
        S_W_SRC,
        S_W_DST,
        S_W_CNT,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_t;

    // DMA slave register map
    localparam logic [31:0] DMA_START_ADDR = 32'hF000_0000;
    localparam logic [31:0] SRC_ADDR       = 32'hF000_0004;
    localparam logic [31:0] DST_ADDR       = 32'hF000_0008;
    localparam logic [31:0] CNT_ADDR       = 32'hF000_0010;

    // START register codes: interrupt the CPU on completion, or complete silently
    localparam logic [31:0] START_IRQ    = 32'd1;
    localparam logic [31:0] START_SILENT = 32'd2;

endpackage

// File: rtl/dma_xfer_scheduler_rr_arbiter.sv
// rtl/dma_xfer_scheduler_rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    grant_idx
);

    int   idx;
    logic found;

    // Walk the requesters cyclically from ptr; the first pending one wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/dma_xfer_scheduler.sv
// rtl/dma_xfer_scheduler.sv - shares one DMA engine among requesters; optional WAIT watchdog via DMA_SCHED_TIMEOUT_EN
module dma_xfer_scheduler #(
    parameter int N_REQ = 4,
    parameter int AW    = 32,
    parameter int TMO_W = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [N_REQ-1:0]                          req_valid,
    output logic [N_REQ-1:0]                          req_ready,
    input  logic [N_REQ*AW-1:0]                       req_src,
    input  logic [N_REQ*AW-1:0]                       req_dst,
    input  logic [N_REQ*AW-1:0]                       req_cnt,
    input  logic [N_REQ-1:0]                          req_irq,
    output logic [AW-1:0]                             cfg_addr,
    output logic [AW-1:0]                             cfg_data,
    output logic                                      cfg_last,
    input  logic                                      cfg_ready,
    output logic                                      dma_load,
    input  logic                                      dma_done,
    output logic                                      busy,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] cur_id,
    output logic                                      done_id_valid,
    output logic                                      err
);

    import dma_sched_pkg::*;

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   cur_id_q;
    logic [AW-1:0]   src_q;
    logic [AW-1:0]   dst_q;
    logic [AW-1:0]   cnt_q;
    logic            irq_q;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_take;
    logic            tmo_hit;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign grant_take = (state == S_IDLE) && (|req_valid);
    assign cur_id     = cur_id_q;

`ifdef DMA_SCHED_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    // The counter has reached all-ones once this WAIT cycle's increment lands
    assign tmo_hit = (state == S_WAIT) && !dma_done && (tmo_cnt == ~TMO_W'(1));
    assign err     = err_q;

    // Watchdog: cleared in LOAD, counts WAIT cycles; error is sticky until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == S_LOAD) begin
                tmo_cnt <= '0;
            end else if (state == S_WAIT) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the winning descriptor at grant; advance the pointer past the served requester
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            cur_id_q <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (grant_take) begin
                cur_id_q <= grant_idx;
                src_q    <= req_src[int'(grant_idx)*AW +: AW];
                dst_q    <= req_dst[int'(grant_idx)*AW +: AW];
                cnt_q    <= req_cnt[int'(grant_idx)*AW +: AW];
                irq_q    <= req_irq[grant_idx];
            end
            if (state == S_DONE) begin
                ptr_q <= (int'(cur_id_q) == N_REQ - 1) ? '0 : cur_id_q + IW'(1);
            end
        end
    end

    // Next state and outputs: register programming replay, load handshake, completion
    always_comb begin
        state_nxt     = state;
        req_ready     = '0;
        cfg_addr      = '0;
        cfg_data      = '0;
        cfg_last      = 1'b0;
        dma_load      = 1'b0;
        done_id_valid = 1'b0;
        busy          = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (!rst && (|req_valid)) begin
                    req_ready = grant;
                    state_nxt = S_W_START;
                end
            end
            S_W_START: begin
                cfg_addr = AW'(DMA_START_ADDR);
                cfg_data = irq_q ? AW'(START_IRQ) : AW'(START_SILENT);
                cfg_last = 1'b1;
                if (cfg_ready) state_nxt = S_W_SRC;
            end
            S_W_SRC: begin
                cfg_addr = AW'(SRC_ADDR);
                cfg_data = src_q;
                cfg_last = 1'b1;
                if (cfg_ready) state_nxt = S_W_DST;
            end
            S_W_DST: begin
                cfg_addr = AW'(DST_ADDR);
                cfg_data = dst_q;
                cfg_last = 1'b1;
                if (cfg_ready) state_nxt = S_W_CNT;
            end
            S_W_CNT: begin
                cfg_addr = AW'(CNT_ADDR);
                cfg_data = cnt_q;
                cfg_last = 1'b1;
                if (cfg_ready) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                dma_load  = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                dma_load = 1'b1;
                if (dma_done || tmo_hit) state_nxt = S_DONE;
            end
            S_DONE: begin
                done_id_valid = 1'b1;
                state_nxt     = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_xfer_scheduler.sv
// tb/tb_dma_xfer_scheduler.sv - directed self-checking bench for dma_xfer_scheduler
module tb_dma_xfer_scheduler;

    localparam int N_REQ = 4;
    localparam int AW    = 32;
`ifdef DMA_SCHED_TIMEOUT_EN
    localparam int TMO_W = 4;
`else
    localparam int TMO_W = 16;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*AW-1:0] req_src;
    logic [N_REQ*AW-1:0] req_dst;
    logic [N_REQ*AW-1:0] req_cnt;
    logic [N_REQ-1:0]    req_irq;
    logic [AW-1:0]       cfg_addr;
    logic [AW-1:0]       cfg_data;
    logic                cfg_last;
    logic                cfg_ready;
    logic                dma_load;
    logic                dma_done;
    logic                busy;
    logic [1:0]          cur_id;
    logic                done_id_valid;
    logic                err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    dma_xfer_scheduler #(
        .N_REQ (N_REQ),
        .AW    (AW),
        .TMO_W (TMO_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_src       (req_src),
        .req_dst       (req_dst),
        .req_cnt       (req_cnt),
        .req_irq       (req_irq),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .cfg_last      (cfg_last),
        .cfg_ready     (cfg_ready),
        .dma_load      (dma_load),
        .dma_done      (dma_done),
        .busy          (busy),
        .cur_id        (cur_id),
        .done_id_valid (done_id_valid),
        .err           (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic set_desc(input int i, input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] cnt, input logic irq);
        req_src[i*AW +: AW] = src;
        req_dst[i*AW +: AW] = dst;
        req_cnt[i*AW +: AW] = cnt;
        req_irq[i]          = irq;
    endtask

    // Called at a negedge in IDLE with the requester(s) already valid
    task automatic serve(input string tag, input int id, input logic [31:0] src,
                         input logic [31:0] dst, input logic [31:0] cnt, input logic irq,
                         input int stall, input bit scramble);
        int t0;
        logic [31:0] addrs [4];
        logic [31:0] datas [4];
        addrs[0] = 32'hF000_0000; datas[0] = irq ? 32'd1 : 32'd2;
        addrs[1] = 32'hF000_0004; datas[1] = src;
        addrs[2] = 32'hF000_0008; datas[2] = dst;
        addrs[3] = 32'hF000_0010; datas[3] = cnt;
        #1;
        check($sformatf("%s grant", tag), 64'(req_ready), 64'(1 << id));
        step;
        if (scramble) req_src[id*AW +: AW] = 32'hDEAD_BEEF;
        check($sformatf("%s ready_pulse", tag), 64'(req_ready), 64'd0);
        check($sformatf("%s busy", tag), 64'(busy), 64'd1);
        check($sformatf("%s cur_id", tag), 64'(cur_id), 64'(id));
        t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s <= stall; s++) begin
                cfg_ready = (s == stall);
                #1;
                check($sformatf("%s w%0d.%0d last", tag, k, s), 64'(cfg_last), 64'd1);
                check($sformatf("%s w%0d.%0d addr", tag, k, s), 64'(cfg_addr), 64'(addrs[k]));
                check($sformatf("%s w%0d.%0d data", tag, k, s), 64'(cfg_data), 64'(datas[k]));
                step;
            end
        end
        cfg_ready = 1'b0;
        check($sformatf("%s prog_cycles", tag), 64'(cyc - t0), 64'(4 * (stall + 1)));
        check($sformatf("%s load", tag), 64'(dma_load), 64'd1);
        check($sformatf("%s last_drop", tag), 64'(cfg_last), 64'd0);
        step;
        check($sformatf("%s wait_load", tag), 64'(dma_load), 64'd1);
        step;
        check($sformatf("%s wait_nodone", tag), 64'(done_id_valid), 64'd0);
        dma_done = 1'b1;
        step;
        dma_done = 1'b0;
        check($sformatf("%s done_valid", tag), 64'(done_id_valid), 64'd1);
        check($sformatf("%s done_id", tag), 64'(cur_id), 64'(id));
        check($sformatf("%s load_off", tag), 64'(dma_load), 64'd0);
        step;
        check($sformatf("%s idle", tag), 64'(busy), 64'd0);
        check($sformatf("%s done_pulse", tag), 64'(done_id_valid), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'hF;
        req_src   = '0;
        req_dst   = '0;
        req_cnt   = '0;
        req_irq   = '0;
        cfg_ready = 1'b0;
        dma_done  = 1'b0;
        step;
        step;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst req_ready", 64'(req_ready), 64'd0);
        check("rst cfg_last", 64'(cfg_last), 64'd0);
        check("rst cfg_addr", 64'(cfg_addr), 64'd0);
        check("rst dma_load", 64'(dma_load), 64'd0);
        check("rst done", 64'(done_id_valid), 64'd0);
        check("rst cur_id", 64'(cur_id), 64'd0);
        check("rst err", 64'(err), 64'd0);
        req_valid = '0;
        rst       = 1'b0;
        step;

        // single request, interrupting START
        set_desc(0, 32'h0000_1000, 32'hD555_0000, 32'd3, 1'b1);
        req_valid = 4'b0001;
        serve("t1", 0, 32'h0000_1000, 32'hD555_0000, 32'd3, 1'b1, 0, 1'b0);
        req_valid = '0;

        // silent START
        set_desc(1, 32'h0000_2000, 32'h0000_3000, 32'd7, 1'b0);
        req_valid = 4'b0010;
        serve("t2", 1, 32'h0000_2000, 32'h0000_3000, 32'd7, 1'b0, 0, 1'b0);
        req_valid = '0;

        // stalled slave, source changed after grant
        set_desc(2, 32'hAAAA_0000, 32'hBBBB_0000, 32'h0000_00FF, 1'b1);
        req_valid = 4'b0100;
        serve("t3", 2, 32'hAAAA_0000, 32'hBBBB_0000, 32'h0000_00FF, 1'b1, 3, 1'b1);
        req_valid = '0;

        // round robin from a fresh pointer
        rst = 1'b1;
        step;
        rst = 1'b0;
        step;
        set_desc(0, 32'h0000_0100, 32'h0000_0200, 32'd10, 1'b1);
        set_desc(1, 32'h0000_1100, 32'h0000_1200, 32'd11, 1'b0);
        set_desc(2, 32'h0000_2100, 32'h0000_2200, 32'd12, 1'b1);
        set_desc(3, 32'h0000_3100, 32'h0000_3200, 32'd13, 1'b0);
        req_valid = 4'hF;
        for (int n = 0; n < 8; n++) begin
            serve($sformatf("rr%0d", n), n % 4, 32'h100 + 32'((n % 4) * 32'h1000),
                  32'h200 + 32'((n % 4) * 32'h1000), 32'(10 + n % 4), ((n % 4) % 2) == 0, 0, 1'b0);
        end
        req_valid = '0;

        // reset mid-programming restores the pointer to 0
        req_valid = 4'b0010;
        serve("t5a", 1, 32'h0000_1100, 32'h0000_1200, 32'd11, 1'b0, 0, 1'b0);
        req_valid = 4'b0100;
        cfg_ready = 1'b1;
        step;
        step;
        step;
        check("t5 in_dst", 64'(cfg_addr), 64'h0000_0000_F000_0008);
        rst = 1'b1;
        #1;
        check("t5 busy", 64'(busy), 64'd0);
        check("t5 cfg_last", 64'(cfg_last), 64'd0);
        check("t5 dma_load", 64'(dma_load), 64'd0);
        step;
        check("t5 busy2", 64'(busy), 64'd0);
        rst       = 1'b0;
        cfg_ready = 1'b0;
        req_valid = 4'hF;
        serve("t5b", 0, 32'h0000_0100, 32'h0000_0200, 32'd10, 1'b1, 0, 1'b0);
        req_valid = '0;

`ifdef DMA_SCHED_TIMEOUT_EN
        begin
            int  nwait;
            bit  seen;
            nwait = 0;
            seen  = 1'b0;
            req_valid = 4'b1000;
            cfg_ready = 1'b1;
            step;
            req_valid = '0;
            step;
            step;
            step;
            step;
            cfg_ready = 1'b0;
            check("tmo load", 64'(dma_load), 64'd1);
            for (int i = 0; i < 40; i++) begin
                step;
                if (done_id_valid) begin
                    seen = 1'b1;
                    break;
                end
                nwait++;
            end
            check("tmo done_seen", 64'(seen), 64'd1);
            check("tmo wait_cycles", 64'(nwait), 64'd15);
            check("tmo err", 64'(err), 64'd1);
            check("tmo cur_id", 64'(cur_id), 64'd3);
            check("tmo load_off", 64'(dma_load), 64'd0);
            step;
            check("tmo idle", 64'(busy), 64'd0);
            check("tmo err_sticky", 64'(err), 64'd1);
        end
`else
        check("err tied", 64'(err), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_xfer_scheduler.md
Name: dma_xfer_scheduler

Overview:
- Shares the single DMA engine between N_REQ requesters, e.g. CPU software path and CNN image/weight/bias loaders.
- Arbitrates round-robin among pending transfer descriptors (src, dst, count, irq flag).
- Replays the DMA register-programming sequence START, SRC, DST, CNT on the DMA slave config port, pulses load, then waits for completion before granting the next requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- AW, 32, address/data width.
- TMO_W, 16, watchdog counter width (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  descriptor valid per requester
- req_ready  out  N_REQ  descriptor accepted; one-cycle pulse to the granted requester
- req_src  in  N_REQ*AW  source address, slice i belongs to requester i
- req_dst  in  N_REQ*AW  destination address
- req_cnt  in  N_REQ*AW  word count minus one (DMA convention)
- req_irq  in  N_REQ  1 = DMA interrupts CPU on completion (START value 1); 0 = silent (START value 2)
- cfg_addr  out  AW  DMA register address
- cfg_data  out  AW  DMA register data
- cfg_last  out  1  write strobe, held until cfg_ready
- cfg_ready  in  1  DMA slave accepted the current write
- dma_load  out  1  load pulse to DMA, held until dma_done
- dma_done  in  1  one-cycle pulse when the DMA leaves FINISH
- busy  out  1  transfer in progress
- cur_id  out  $clog2(N_REQ)  requester being served
- done_id_valid  out  1  one-cycle pulse at completion
- err  out  1  sticky timeout error (optional feature only; else tied 0)

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; latched descriptor 0.
- States: IDLE, W_START, W_SRC, W_DST, W_CNT, LOAD, WAIT, DONE.
- IDLE:
  - If any req_valid: grant per round-robin starting at pointer, pulse req_ready[g] for one cycle, latch the descriptor and cur_id=g.
  - Next state W_START. A grant costs 1 cycle.
- W_START: cfg_addr=F000_0000, cfg_data = req_irq ? 1 : 2, cfg_last=1. On cfg_ready go to W_SRC.
- W_SRC: cfg_addr=F000_0004, data=src. On cfg_ready go to W_DST.
- W_DST: cfg_addr=F000_0008, data=dst. On cfg_ready go to W_CNT.
- W_CNT: cfg_addr=F000_0010, data=cnt. On cfg_ready go to LOAD.
- cfg_addr/cfg_data are stable for as long as cfg_last is high. cfg_last drops the cycle after acceptance. Writes are strictly back-to-back with no overlap.
- LOAD: dma_load=1. Go to WAIT next cycle; dma_load stays 1 through WAIT.
- WAIT: on dma_done, dma_load=0 and go to DONE.
- DONE:
  - Pulse done_id_valid with cur_id.
  - Pointer = cur_id+1, wrapping modulo N_REQ.
  - Return to IDLE. Back-to-back transfers therefore incur 1 idle cycle.
- busy=1 in every state except IDLE.
- Descriptor inputs are sampled only at grant; later changes are ignored.
- A requester that drops req_valid before grant is simply skipped.
- dma_done outside WAIT is ignored.
- cfg_ready outside W_* states is ignored.
- All requesters valid: grants rotate 0,1,2,3,0... with no starvation.
- Single requester continuously valid: served back-to-back.
- Reset mid-operation: returns immediately to IDLE with outputs 0. The DMA itself is reset on the same rst.
- No arithmetic beyond the pointer wrap and the watchdog counter. cnt is passed through unmodified.

Optional Feature:
- Macro DMA_SCHED_TIMEOUT_EN.
- Defined:
  - A TMO_W-bit counter clears on entry to LOAD and increments each cycle in WAIT.
  - When it reaches all-ones without dma_done: set err (sticky until rst), pulse done_id_valid, drop dma_load, go to DONE.
- Undefined: no counter, err tied 0, WAIT is unbounded.

Decomposition:
- Package dma_sched_pkg:
  - State enum.
  - Register address constants DMA_START_ADDR=F000_0000, SRC_ADDR=F000_0004, DST_ADDR=F000_0008, CNT_ADDR=F000_0010.
  - START codes START_IRQ=1, START_SILENT=2.
- One sub-module, rr_arbiter:
  - Parameter N_REQ; inputs req vector and pointer; outputs one-hot grant and grant index.
  - Purely combinational.

Test Plan:
- Single request: req0 src=1000, dst=D5550000, cnt=3, irq=1, cfg_ready always 1 → writes (F0000000,1),(F0000004,1000),(F0000008,D5550000),(F0000010,3) on 4 consecutive cycles; dma_load high until dma_done; done_id_valid with cur_id=0.
- irq=0 → START data=2.
- cfg_ready stalled 3 cycles per write → cfg_addr/cfg_data held constant; total programming takes 16 cycles.
- All 4 requesters valid continuously, 8 transfers → grant order 0,1,2,3,0,1,2,3; each req_ready is a one-cycle pulse.
- req_src changed after grant → cfg_data still shows the latched value.
- rst asserted during W_DST → next cycle busy=0, cfg_last=0, dma_load=0; a new request afterward is granted to requester 0.
- With DMA_SCHED_TIMEOUT_EN and TMO_W=4, dma_done withheld → err=1 after 15 WAIT cycles, done_id_valid pulses, scheduler returns to IDLE.
